// File: rtl/control_pulp_pkg.sv
// Shared AXI4 payload types, single-beat burst constants and checker FSM
// state encodings for the AXI write/read-back checker.
package control_pulp_pkg;

  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;
  localparam int unsigned AxiIdWidth   = 4;

  typedef logic [AxiAddrWidth-1:0] axi_addr_ext_t;
  typedef logic [AxiDataWidth-1:0] axi_data_inp_ext_t;
  typedef logic [AxiStrbWidth-1:0] axi_strb_t;
  typedef logic [AxiIdWidth-1:0]   axi_id_t;

  // Single-beat burst attributes: full-width beat, INCR.
  localparam logic [2:0] AxiSizeBeat  = 3'($clog2(AxiStrbWidth));
  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  typedef struct packed {
    axi_id_t       id;
    axi_addr_ext_t addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } axi_ax_t;

  typedef struct packed {
    axi_data_inp_ext_t data;
    axi_strb_t         strb;
    logic              last;
  } axi_w_t;

  typedef struct packed {
    axi_id_t    id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    axi_id_t           id;
    axi_data_inp_ext_t data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;

  // Checker FSM state encodings.
  typedef logic [2:0] chk_state_t;
  localparam chk_state_t StIdle   = 3'd0;
  localparam chk_state_t StWrite  = 3'd1;
  localparam chk_state_t StWresp  = 3'd2;
  localparam chk_state_t StRead   = 3'd3;
  localparam chk_state_t StRdata  = 3'd4;
  localparam chk_state_t StReport = 3'd5;

endpackage

// File: rtl/axi_wr_rd_checker_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clr (sync clear), inc (count enable), cnt (current value).
module axi_chk_sat_cnt #(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                inc,
  output logic [CntWidth-1:0] cnt
);

  // Hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CntWidth'(1);
    end
  end

endmodule

// File: rtl/axi_wr_rd_checker.sv
// AXI4 write/read-back checker: accepts an address/data stimulus pair, writes
// it with a single-beat burst, reads it back, and reports a pass/fail result
// with the first non-OKAY response and running transaction/error counters.
// Ports: clk_i/rst_i (sync active-high), stim_* (stimulus handshake),
// axi_req_o/axi_rsp_i (AXI4 master), res_* (result handshake),
// txn_cnt_o/err_cnt_o (saturating counters), busy_o (not idle).
module axi_wr_rd_checker
  import control_pulp_pkg::*;
#(
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stim_valid_i,
  output logic                stim_ready_o,
  input  axi_addr_ext_t       stim_addr_i,
  input  axi_data_inp_ext_t   stim_data_i,
  output axi_req_t            axi_req_o,
  input  axi_resp_t           axi_rsp_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic                res_mismatch_o,
  output axi_data_inp_ext_t   res_rdata_o,
  output logic [1:0]          res_resp_o,
  output logic [CntWidth-1:0] txn_cnt_o,
  output logic [CntWidth-1:0] err_cnt_o,
  output logic                busy_o
);

  localparam int unsigned WdWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  chk_state_t state_q, state_d;

  axi_addr_ext_t     addr_q;
  axi_data_inp_ext_t data_q;
  logic              aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
  logic [1:0]        bresp_q;
  logic [WdWidth-1:0] wd_cnt_q;
  logic              expired_q, expired_d, wd_active;
  axi_data_inp_ext_t res_rdata_q;
  logic [1:0]        res_resp_q;
  logic              res_mismatch_q;

  logic stim_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, res_hs;
  logic aw_ok, w_ok;

  assign stim_hs = (state_q == StIdle) && stim_valid_i;
  assign aw_hs   = aw_valid_q && axi_rsp_i.aw_ready;
  assign w_hs    = w_valid_q && axi_rsp_i.w_ready;
  assign b_hs    = b_ready_q && axi_rsp_i.b_valid;
  assign ar_hs   = ar_valid_q && axi_rsp_i.ar_ready;
  assign r_hs    = r_ready_q && axi_rsp_i.r_valid;
  assign res_hs  = (state_q == StReport) && res_ready_i;

  // AW and W complete independently; a dropped valid means that channel is done.
  assign aw_ok = !aw_valid_q || axi_rsp_i.aw_ready;
  assign w_ok  = !w_valid_q || axi_rsp_i.w_ready;

  // Watchdog covers the whole AXI phase; expiry is sticky and only flags the result.
  assign wd_active = (state_q == StWrite) || (state_q == StWresp) ||
                     (state_q == StRead)  || (state_q == StRdata);
  assign expired_d = expired_q ||
                     (wd_active && (wd_cnt_q == WdWidth'(TimeoutCycles - 1)));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (stim_hs)      state_d = StWrite;
      StWrite:  if (aw_ok && w_ok) state_d = StWresp;
      StWresp:  if (b_hs)         state_d = StRead;
      StRead:   if (ar_hs)        state_d = StRdata;
      StRdata:  if (r_hs)         state_d = StReport;
      StReport: if (res_hs)       state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  // Channel handshakes, latched stimulus, watchdog and result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q         <= '0;
      data_q         <= '0;
      aw_valid_q     <= 1'b0;
      w_valid_q      <= 1'b0;
      b_ready_q      <= 1'b0;
      ar_valid_q     <= 1'b0;
      r_ready_q      <= 1'b0;
      bresp_q        <= '0;
      wd_cnt_q       <= '0;
      expired_q      <= 1'b0;
      res_rdata_q    <= '0;
      res_resp_q     <= '0;
      res_mismatch_q <= 1'b0;
    end else begin
      b_ready_q  <= (state_d == StWresp);
      ar_valid_q <= (state_d == StRead);
      r_ready_q  <= (state_d == StRdata);

      if (stim_hs) begin
        addr_q     <= stim_addr_i;
        data_q     <= stim_data_i;
        aw_valid_q <= 1'b1;
        w_valid_q  <= 1'b1;
        wd_cnt_q   <= '0;
        expired_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_valid_q <= 1'b0;
        if (w_hs)  w_valid_q  <= 1'b0;
        if (wd_active && !expired_q) wd_cnt_q <= wd_cnt_q + WdWidth'(1);
        expired_q <= expired_d;
      end

      if (b_hs) bresp_q <= axi_rsp_i.b.resp;

      // B response takes precedence over R when reporting the failing response.
      if (r_hs) begin
        res_rdata_q    <= axi_rsp_i.r.data;
        res_resp_q     <= (bresp_q != AxiRespOkay) ? bresp_q : axi_rsp_i.r.resp;
        res_mismatch_q <= (axi_rsp_i.r.data != data_q) ||
                          (bresp_q != AxiRespOkay) ||
                          (axi_rsp_i.r.resp != AxiRespOkay) ||
                          expired_d;
      end
    end
  end

  // AXI request assembly from registered valids/readies and latched payload.
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.len   = 8'd0;
    axi_req_o.aw.size  = AxiSizeBeat;
    axi_req_o.aw.burst = AxiBurstIncr;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = data_q;
    axi_req_o.w.strb   = '1;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.len   = 8'd0;
    axi_req_o.ar.size  = AxiSizeBeat;
    axi_req_o.ar.burst = AxiBurstIncr;
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

  assign stim_ready_o   = (state_q == StIdle) && !rst_i;
  assign res_valid_o    = (state_q == StReport) && !rst_i;
  assign busy_o         = (state_q != StIdle);
  assign res_mismatch_o = res_mismatch_q;
  assign res_rdata_o    = res_rdata_q;
  assign res_resp_o     = res_resp_q;

  // Response IDs and r.last carry no information for single-beat, id-0 traffic.
  logic unused_rsp_fields;
  assign unused_rsp_fields = ^{axi_rsp_i.b.id, axi_rsp_i.r.id, axi_rsp_i.r.last};

  axi_chk_sat_cnt #(.CntWidth(CntWidth)) u_txn_cnt (
    .clk (clk_i),
    .clr (rst_i),
    .inc (res_hs),
    .cnt (txn_cnt_o)
  );

  axi_chk_sat_cnt #(.CntWidth(CntWidth)) u_err_cnt (
    .clk (clk_i),
    .clr (rst_i),
    .inc (res_hs && res_mismatch_q),
    .cnt (err_cnt_o)
  );

endmodule

// File: tb/tb_axi_wr_rd_checker.sv
// Directed bench for axi_wr_rd_checker with a small zero-wait memory slave.
// Counters are built 4 bits wide so all-ones saturation is reachable quickly.
module tb_axi_wr_rd_checker;
  import control_pulp_pkg::*;

  localparam int unsigned TbCntWidth = 4;
  localparam int unsigned TbTimeout  = 1024;

  logic clk = 1'b0;
  logic rst;
  logic stim_valid, stim_ready;
  axi_addr_ext_t stim_addr;
  axi_data_inp_ext_t stim_data;
  axi_req_t axi_req;
  axi_resp_t axi_rsp;
  logic res_valid, res_ready, res_mismatch;
  axi_data_inp_ext_t res_rdata;
  logic [1:0] res_resp;
  logic [TbCntWidth-1:0] txn_cnt, err_cnt;
  logic busy;

  int n_cmp = 0;
  int n_fail = 0;
  logic [TbCntWidth-1:0] exp_txn, exp_err;

  always #5 clk = ~clk;

  axi_wr_rd_checker #(.CntWidth(TbCntWidth), .TimeoutCycles(TbTimeout)) dut (
    .clk_i(clk), .rst_i(rst),
    .stim_valid_i(stim_valid), .stim_ready_o(stim_ready),
    .stim_addr_i(stim_addr), .stim_data_i(stim_data),
    .axi_req_o(axi_req), .axi_rsp_i(axi_rsp),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_mismatch_o(res_mismatch), .res_rdata_o(res_rdata), .res_resp_o(res_resp),
    .txn_cnt_o(txn_cnt), .err_cnt_o(err_cnt), .busy_o(busy)
  );

  // ---------------- memory-model slave ----------------
  logic aw_block, rdata_ovr_en;
  logic [1:0] bresp_cfg, rresp_cfg;
  axi_data_inp_ext_t rdata_ovr;
  logic aw_seen, w_seen, b_pend, r_pend;
  axi_addr_ext_t wr_addr;
  axi_data_inp_ext_t wr_data, rd_data;
  axi_data_inp_ext_t mem [16];

  always_comb begin
    axi_rsp          = '0;
    axi_rsp.aw_ready = !aw_block && !aw_seen;
    axi_rsp.w_ready  = !w_seen;
    axi_rsp.b_valid  = b_pend;
    axi_rsp.b.resp   = bresp_cfg;
    axi_rsp.ar_ready = !r_pend;
    axi_rsp.r_valid  = r_pend;
    axi_rsp.r.data   = rd_data;
    axi_rsp.r.resp   = rresp_cfg;
    axi_rsp.r.last   = 1'b1;
  end

  logic s_aw_hs, s_w_hs;
  assign s_aw_hs = axi_req.aw_valid && axi_rsp.aw_ready;
  assign s_w_hs  = axi_req.w_valid && axi_rsp.w_ready;

  always @(posedge clk) begin
    if (rst) begin
      aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      wr_addr <= '0; wr_data <= '0; rd_data <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (s_aw_hs) begin aw_seen <= 1'b1; wr_addr <= axi_req.aw.addr; end
      if (s_w_hs)  begin w_seen  <= 1'b1; wr_data <= axi_req.w.data;  end
      if ((aw_seen || s_aw_hs) && (w_seen || s_w_hs) && !b_pend) begin
        mem[s_aw_hs ? axi_req.aw.addr[19:16] : wr_addr[19:16]] <= s_w_hs ? axi_req.w.data : wr_data;
        b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end
      if (b_pend && axi_req.b_ready) b_pend <= 1'b0;
      if (axi_req.ar_valid && !r_pend) begin
        r_pend  <= 1'b1;
        rd_data <= rdata_ovr_en ? rdata_ovr : mem[axi_req.ar.addr[19:16]];
      end
      if (r_pend && axi_req.r_ready) r_pend <= 1'b0;
    end
  end

  function automatic logic [TbCntWidth-1:0] sat_inc(input logic [TbCntWidth-1:0] v);
    return (v == '1) ? v : v + TbCntWidth'(1);
  endfunction

  // ---------------- drivers ----------------
  task automatic send_stim(input axi_addr_ext_t a, input axi_data_inp_ext_t d, output bit ok);
    int n = 0;
    @(negedge clk);
    stim_valid = 1'b1; stim_addr = a; stim_data = d;
    while (!stim_ready && n < 50) begin @(negedge clk); n++; end
    ok = stim_ready;
    @(posedge clk); #1;
    stim_valid = 1'b0;
  endtask

  // Called at active edge + 1 right after the stimulus handshake edge.
  task automatic wait_result(input int bound, output int lat);
    lat = 1;
    while (!res_valid && lat < bound) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (stim_ready !== 1'b0) begin n_fail++; $display("FAIL reset_stim_ready: got %0h want 0", stim_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready, res_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_valids: got %b want 000000", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready, res_valid}); end
    n_cmp++; if ({txn_cnt, err_cnt} !== '0) begin n_fail++; $display("FAIL reset_cnts: got %h want 0", {txn_cnt, err_cnt}); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (stim_ready !== 1'b1) begin n_fail++; $display("FAIL idle_stim_ready: got %0h want 1", stim_ready); end
    exp_txn = '0; exp_err = '0;
  endtask

  task automatic test_basic();
    bit ok; int lat;
    send_stim(32'h1C00_0000, 64'h0000_0000_cafe_cafe, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %0h want 1", ok); end
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid, busy, stim_ready} !== 4'b1110) begin
      n_fail++; $display("FAIL basic_write_phase: got %b want 1110", {axi_req.aw_valid, axi_req.w_valid, busy, stim_ready}); end
    n_cmp++; if (axi_req.aw.addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL basic_aw_addr: got %h want 1c000000", axi_req.aw.addr); end
    n_cmp++; if ({axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.aw.id} !== {8'd0, 3'd3, 2'b01, 4'd0}) begin
      n_fail++; $display("FAIL basic_aw_attr: got %h want %h", {axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.aw.id}, {8'd0, 3'd3, 2'b01, 4'd0}); end
    n_cmp++; if ({axi_req.w.strb, axi_req.w.last} !== {8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL basic_w_attr: got %h want 1ff", {axi_req.w.strb, axi_req.w.last}); end
    n_cmp++; if (axi_req.w.data !== 64'h0000_0000_cafe_cafe) begin n_fail++; $display("FAIL basic_w_data: got %h want cafecafe", axi_req.w.data); end
    wait_result(40, lat);
    n_cmp++; if (lat !== 5 || res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %0d (valid %0h) want 5", lat, res_valid); end
    n_cmp++; if ({res_mismatch, res_resp} !== 3'b000) begin n_fail++; $display("FAIL basic_result: got %b want 000", {res_mismatch, res_resp}); end
    n_cmp++; if (res_rdata !== 64'h0000_0000_cafe_cafe) begin n_fail++; $display("FAIL basic_rdata: got %h want cafecafe", res_rdata); end
    consume();
    exp_txn = sat_inc(exp_txn);
    n_cmp++; if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin n_fail++; $display("FAIL basic_cnts: got %h want %h", {txn_cnt, err_cnt}, {exp_txn, exp_err}); end
    n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 00", {busy, res_valid}); end
  endtask

  task automatic test_data_mismatch();
    bit ok; int lat;
    rdata_ovr_en = 1'b1; rdata_ovr = 64'h0000_0000_cafe_beef;
    send_stim(32'h1C08_0000, 64'h0000_0000_cafe_dead, ok);
    wait_result(40, lat);
    rdata_ovr_en = 1'b0;
    n_cmp++; if (res_valid !== 1'b1 || res_mismatch !== 1'b1) begin n_fail++; $display("FAIL dmis_flag: got %b want 11", {res_valid, res_mismatch}); end
    n_cmp++; if (res_rdata !== 64'h0000_0000_cafe_beef) begin n_fail++; $display("FAIL dmis_rdata: got %h want cafebeef", res_rdata); end
    n_cmp++; if (res_resp !== 2'd0) begin n_fail++; $display("FAIL dmis_resp: got %0d want 0", res_resp); end
    consume();
    exp_txn = sat_inc(exp_txn); exp_err = sat_inc(exp_err);
    n_cmp++; if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin n_fail++; $display("FAIL dmis_cnts: got %h want %h", {txn_cnt, err_cnt}, {exp_txn, exp_err}); end
  endtask

  task automatic test_resp();
    logic [1:0] bcfg [3] = '{2'd2, 2'd0, 2'd2};
    logic [1:0] rcfg [3] = '{2'd0, 2'd3, 2'd3};
    logic [1:0] want [3] = '{2'd2, 2'd3, 2'd2};
    bit ok; int lat;
    for (int i = 0; i < 3; i++) begin
      bresp_cfg = bcfg[i]; rresp_cfg = rcfg[i];
      send_stim(32'h1C01_0000, 64'h1234_5678_0000_0000 + 64'(i), ok);
      wait_result(40, lat);
      n_cmp++; if ({res_valid, res_mismatch, res_resp} !== {2'b11, want[i]}) begin
        n_fail++; $display("FAIL resp_%0d: got %b want %b", i, {res_valid, res_mismatch, res_resp}, {2'b11, want[i]}); end
      n_cmp++; if (res_rdata !== 64'h1234_5678_0000_0000 + 64'(i)) begin n_fail++; $display("FAIL resp_rdata_%0d: got %h", i, res_rdata); end
      consume();
      exp_txn = sat_inc(exp_txn); exp_err = sat_inc(exp_err);
    end
    bresp_cfg = 2'd0; rresp_cfg = 2'd0;
    n_cmp++; if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin n_fail++; $display("FAIL resp_cnts: got %h want %h", {txn_cnt, err_cnt}, {exp_txn, exp_err}); end
  endtask

  task automatic test_timeout();
    bit ok; int lat; int bad = 0;
    aw_block = 1'b1;
    send_stim(32'h1C02_0000, 64'h0bad_f00d_0bad_f00d, ok);
    @(posedge clk); #1;
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid} !== 2'b10) begin
      n_fail++; $display("FAIL tmo_w_drop: got %b want 10", {axi_req.aw_valid, axi_req.w_valid}); end
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (axi_req.aw_valid !== 1'b1 || axi_req.aw.addr !== 32'h1C02_0000 || res_valid !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL tmo_aw_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk); aw_block = 1'b0;
    wait_result(40, lat);
    n_cmp++; if ({res_valid, res_mismatch, res_resp} !== 4'b1100) begin
      n_fail++; $display("FAIL tmo_result: got %b want 1100", {res_valid, res_mismatch, res_resp}); end
    n_cmp++; if (res_rdata !== 64'h0bad_f00d_0bad_f00d) begin n_fail++; $display("FAIL tmo_rdata: got %h", res_rdata); end
    consume();
    exp_txn = sat_inc(exp_txn); exp_err = sat_inc(exp_err);
    n_cmp++; if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin n_fail++; $display("FAIL tmo_cnts: got %h want %h", {txn_cnt, err_cnt}, {exp_txn, exp_err}); end
  endtask

  // Drive failing transactions until the error counter is at all-ones.
  task automatic fill_err_cnt();
    bit ok; int lat;
    rdata_ovr_en = 1'b1; rdata_ovr = '0;
    while (exp_err != '1) begin
      send_stim(32'h1C03_0000, 64'h5555_5555_5555_5555, ok);
      wait_result(40, lat);
      consume();
      exp_txn = sat_inc(exp_txn); exp_err = sat_inc(exp_err);
    end
    rdata_ovr_en = 1'b0;
    n_cmp++; if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin n_fail++; $display("FAIL fill_cnts: got %h want %h", {txn_cnt, err_cnt}, {exp_txn, exp_err}); end
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; int bad_rdy = 0; int bad_hold = 0;
    rdata_ovr_en = 1'b1; rdata_ovr = 64'hdead_dead_dead_dead;
    send_stim(32'h1C04_0000, 64'h1111_2222_3333_4444, ok);
    @(negedge clk);
    stim_valid = 1'b1; stim_addr = 32'h1C05_0000; stim_data = 64'h9999_8888_7777_6666;
    @(posedge clk); #1;
    lat = 2;
    while (!res_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== 5 || res_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency: got %0d want 5", lat); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stim_ready !== 1'b0) bad_rdy++;
      if (res_valid !== 1'b1 || res_mismatch !== 1'b1 || res_rdata !== 64'hdead_dead_dead_dead) bad_hold++;
    end
    n_cmp++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL b2b_stim_blocked: got %0d bad cycles want 0", bad_rdy); end
    n_cmp++; if (bad_hold !== 0) begin n_fail++; $display("FAIL b2b_result_hold: got %0d bad cycles want 0", bad_hold); end
    consume();
    rdata_ovr_en = 1'b0;
    exp_txn = sat_inc(exp_txn); exp_err = sat_inc(exp_err);
    n_cmp++; if (err_cnt !== 4'hF || {txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin
      n_fail++; $display("FAIL b2b_saturate: got %h want %h", {txn_cnt, err_cnt}, {exp_txn, exp_err}); end
    @(negedge clk);
    n_cmp++; if (stim_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ready: got %0h want 1", stim_ready); end
    @(posedge clk); #1; stim_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || axi_req.aw.addr !== 32'h1C05_0000) begin
      n_fail++; $display("FAIL b2b_second_accept: got busy %0h addr %h want 1 1c050000", busy, axi_req.aw.addr); end
    wait_result(40, lat);
    n_cmp++; if ({res_valid, res_mismatch, res_rdata} !== {2'b10, 64'h9999_8888_7777_6666}) begin
      n_fail++; $display("FAIL b2b_second_result: got %b %h", {res_valid, res_mismatch}, res_rdata); end
    consume();
    exp_txn = sat_inc(exp_txn);
    n_cmp++; if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin n_fail++; $display("FAIL b2b_cnts: got %h want %h", {txn_cnt, err_cnt}, {exp_txn, exp_err}); end
  endtask

  task automatic test_reset_mid();
    bit ok; int n = 0; int bad = 0;
    send_stim(32'h1C06_0000, 64'h0f0f_0f0f_0f0f_0f0f, ok);
    @(negedge clk);
    while (!axi_req.r_ready && n < 20) begin @(negedge clk); n++; end
    n_cmp++; if (axi_req.r_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_rdata: got %0h want 1", axi_req.r_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_txn = '0; exp_err = '0;
    n_cmp++; if ({busy, res_valid, stim_ready} !== 3'b000) begin n_fail++; $display("FAIL rmid_state: got %b want 000", {busy, res_valid, stim_ready}); end
    n_cmp++; if ({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready} !== 5'b0) begin
      n_fail++; $display("FAIL rmid_axi: got %b want 00000", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready}); end
    n_cmp++; if ({txn_cnt, err_cnt} !== {exp_txn, exp_err}) begin n_fail++; $display("FAIL rmid_cnts: got %h want 0", {txn_cnt, err_cnt}); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0 || busy !== 1'b0 || stim_ready !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_abandon: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    rst = 1'b1; stim_valid = 1'b0; stim_addr = '0; stim_data = '0; res_ready = 1'b0;
    aw_block = 1'b0; rdata_ovr_en = 1'b0; rdata_ovr = '0; bresp_cfg = 2'd0; rresp_cfg = 2'd0;
    exp_txn = '0; exp_err = '0;
    test_reset();
    test_basic();
    test_data_mismatch();
    test_resp();
    test_timeout();
    fill_err_cnt();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
